// File: rtl/down_counter_pkg.sv
// Shared types for the loadable down-counter/timer.
// Holds the FSM state encoding and the default counter width.
package down_counter_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_t;

endpackage

// File: rtl/down_counter_tc_dec.sv
// Combinational decrementer: ripple-borrow chain of half-subtractors.
// Ports: a (operand), diff (a-1), zero (a==0), one (a==1).
module counter_dec
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] diff,
   output logic             zero,
   output logic             one
);

   logic [WIDTH:0] borrow;

   // Borrow-in of 1 subtracts one; each stage is a half-subtractor.
   assign borrow[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_hs
         assign diff[i]     = a[i] ^ borrow[i];
         assign borrow[i+1] = ~a[i] & borrow[i];
      end
   endgenerate

   // Borrow ripples out of the top only when every bit was zero.
   assign zero = borrow[WIDTH];
   assign one  = a[0] & ~(|a[WIDTH-1:1]);

endmodule

// File: rtl/down_counter_tc.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse.
// Ports: clk, rst_n, load, load_val, start, stop, tick,
//   auto_reload in; count, busy, tc out (all registered).
module down_counter_tc
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   state_t           state;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] dec;
   logic             is_zero;
   logic             is_one;

   counter_dec #(.WIDTH(WIDTH)) u_dec (
      .a    (count),
      .diff (dec),
      .zero (is_zero),
      .one  (is_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         busy   <= 1'b0;
         tc     <= 1'b0;
      end else if (load) begin
         state  <= IDLE;
         count  <= load_val;
         reload <= load_val;
         busy   <= 1'b0;
         tc     <= 1'b0;
      end else begin
         tc <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !stop && !is_zero) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= HOLD;
               end else if (tick) begin
                  if (is_one) begin
                     tc <= 1'b1;
                     if (auto_reload && (reload != '0)) begin
                        count <= reload;
                     end else begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else if (!is_zero) begin
                     // Guard keeps count from wrapping below zero.
                     count <= dec;
                  end
               end
            end
            HOLD: begin
               if (start && !stop) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_down_counter_tc.sv
// Scoreboard bench for down_counter_tc: randomized and directed
// stimulus against a behavioural timer model.
module tb_down_counter_tc;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         tick = 1'b0;
   logic         auto_reload = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int cnt;
      bit bsy;
      bit t;
   } exp_t;

   exp_t q[$];

   // Model state: mode 0 stopped, 1 counting, 2 paused.
   int m_cnt = 0;
   int m_rel = 0;
   int m_mode = 0;
   bit m_tc = 0;

   down_counter_tc #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .tick        (tick),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .tc          (tc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act,
                        input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: advance one clock edge from sampled inputs.
   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         m_cnt = 0; m_rel = 0; m_mode = 0; m_tc = 0;
      end else if (load) begin
         m_cnt = int'(load_val);
         m_rel = int'(load_val);
         m_mode = 0;
         m_tc = 0;
      end else begin
         m_tc = 0;
         if (m_mode == 0) begin
            if (start && !stop && m_cnt > 0) m_mode = 1;
         end else if (m_mode == 1) begin
            if (stop) m_mode = 2;
            else if (tick && m_cnt == 1) begin
               m_tc = 1;
               if (auto_reload && m_rel > 0) m_cnt = m_rel;
               else begin
                  m_cnt = 0;
                  m_mode = 0;
               end
            end else if (tick && m_cnt > 1) m_cnt = m_cnt - 1;
         end else begin
            if (start && !stop) m_mode = 1;
         end
      end
      e.cnt = m_cnt;
      e.bsy = (m_mode != 0);
      e.t = m_tc;
      q.push_back(e);
   end

   // Monitor: outputs are valid every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("count", int'(count), e.cnt);
         check("busy", int'(busy), int'(e.bsy));
         check("tc", int'(tc), int'(e.t));
      end
   end

   // One edge of stimulus; inputs change at negedge+1.
   task automatic drv(input bit l, input int lv, input bit s,
                      input bit p, input bit t, input bit ar);
      load = l;
      load_val = W'(lv);
      start = s;
      stop = p;
      tick = t;
      auto_reload = ar;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_n(input int n, input bit t, input bit ar);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, t, ar);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_count", int'(count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_tc", int'(tc), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Basic countdown from 5.
      drv(1, 5, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(8, 1, 0);

      // Pause and resume.
      drv(1, 10, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(3, 1, 0);
      drv(0, 0, 0, 1, 1, 0);
      idle_n(4, 1, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(9, 1, 0);

      // Auto-reload, then drop it.
      drv(1, 3, 0, 0, 0, 1);
      drv(0, 0, 1, 0, 0, 1);
      idle_n(9, 1, 1);
      idle_n(5, 1, 0);

      // Boundaries: load 0, load 1, load FF with gated tick.
      drv(1, 0, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 1, 0);
      idle_n(2, 1, 0);
      drv(1, 1, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(3, 1, 0);
      drv(1, 255, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 520; i++) drv(0, 0, 0, 0, i[0], 0);

      // Simultaneous events.
      drv(1, 6, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 1, 1, 0);
      drv(0, 0, 1, 1, 1, 0);
      drv(0, 0, 1, 0, 1, 0);
      drv(1, 9, 0, 1, 1, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(8, 1, 0);
      drv(1, 4, 0, 0, 1, 0);

      // Reset between edges during a run.
      drv(1, 20, 0, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      idle_n(5, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_count", int'(count), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_tc", int'(tc), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      drv(0, 0, 1, 0, 1, 0);
      idle_n(3, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int lv;
         lv = ($urandom_range(0, 9) == 0) ?
              int'($urandom_range(0, 255)) :
              int'($urandom_range(0, 6));
         drv($urandom_range(0, 29) == 0, lv,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 1) == 1);
      end

      idle_n(3, 0, 0);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/down_counter_tc.md
Name: down_counter_tc

Overview:
- Loadable down-counter/timer; the decrementing counterpart of the team's incrementer-based counter.
- Counts a programmed value down to zero, pulses terminal count, and optionally auto-reloads.
- Sits beside the up-counter as a timeout/interval source for control logic.
- Decrement datapath is a ripple-borrow chain in its own sub-module, mirroring the incrementer's half-adder carry chain.

Parameters:
- WIDTH, 8, counter/load width in bits (min 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  load strobe; copies load_val into count and reload register.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin/resume counting.
- stop  input  1  pause counting.
- tick  input  1  count enable (prescaler strobe); one decrement per cycle with tick=1 in RUN.
- auto_reload  input  1  1 = reload from reload register at terminal count and keep running.
- count  output  WIDTH  current count value (registered).
- busy  output  1  1 when state is RUN or HOLD.
- tc  output  1  terminal-count pulse, exactly one cycle wide (registered).

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, reload register=0, state=IDLE, busy=0, tc=0. Effective immediately; aborts any run.
- States:
  - IDLE: not counting.
  - RUN: decrementing on tick.
  - HOLD: paused, count frozen.
- Input priority per edge: load > stop > start > tick-decrement.
- load (any state): count<=load_val; reload<=load_val; state<=IDLE; tc<=0.
- IDLE:
  - start with count!=0 -> RUN.
  - start with count==0 -> ignored, stays IDLE, no tc.
  - tick is ignored.
- RUN:
  - stop -> HOLD, count unchanged.
  - tick=1 and count>1 -> count<=count-1.
  - tick=1 and count==1 (terminal):
    - tc<=1 for the next cycle.
    - If auto_reload=1 and reload!=0: count<=reload, stay RUN.
    - Else: count<=0, state<=IDLE.
  - tick=0 -> hold value.
  - start while in RUN has no effect.
- HOLD:
  - start (without stop) -> RUN.
  - stop or tick have no effect.
  - count frozen.
- start and stop together: stop wins (RUN->HOLD; HOLD stays; IDLE stays IDLE).
- Latency: start sampled at edge k makes RUN visible after k. The first decrement occurs at the first edge >k with tick=1. With tick held 1 and load value N, count reaches 0 (or reloads) at edge k+N. tc is high in the cycle after edge k+N.
- tc is 0 in every cycle not immediately following a terminal decrement. A load on the terminal edge suppresses tc (load priority).
- No underflow: count never decrements from 0; no wrap to all-ones.
- busy is a registered decode: busy = (state!=IDLE).
- auto_reload is sampled only at the terminal edge. Changing it mid-run is legal.

Decomposition:
- Shared package down_counter_pkg holds:
  - state typedef (IDLE=2'b00, RUN=2'b01, HOLD=2'b10).
  - default WIDTH constant.
- Sub-module counter_dec (combinational):
  - Inputs: A[WIDTH-1:0]. Outputs: DIFF=A-1, zero flag (A==0), one flag (A==1).
  - Built as a ripple-borrow chain of half-subtractor stages, structurally parallel to the incrementer.
- The top holds the FSM, the count/reload registers and tc.

Test Plan:
- Basic countdown: reset, load_val=5, load, start, tick=1 continuously -> count 5,4,3,2,1,0 on successive cycles; tc=1 for exactly one cycle coincident with count==0; busy falls the same cycle; state IDLE.
- Pause/resume: load 10, start, tick=1 for 3 cycles (count=7), stop, 4 ticks -> count stays 7, busy=1. Then start -> resumes 6,5,...; tc after 7 more ticks.
- Auto-reload: load 3, auto_reload=1, start, tick=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1 pattern; tc pulses at 3, 6 and 9 ticks; busy stays 1. Then clear auto_reload -> next terminal ends at count=0, IDLE.
- Boundaries:
  - load 0, start -> stays IDLE, no tc, busy=0.
  - load 1, start, one tick -> count 0, single tc.
  - load 8'hFF with tick gated every 2nd cycle -> tc after 255 ticks (510 cycles); count never reads 8'hFF after a decrement.
- Simultaneous events:
  - start+stop while RUN -> HOLD.
  - load+stop while RUN -> count=load_val, IDLE.
  - load on the terminal edge -> no tc, count=load_val.
- Reset mid-run: load 20, start, 5 ticks, assert rst_n=0 asynchronously between edges -> count=0, busy=0, tc=0 immediately. After release, start is ignored (count 0).
